// File: rtl/issue_pair_scheduler.sv
// Dual-issue pair scheduler: issues a decoded pair together, or splits it over two
// cycles when slot 1 cannot safely issue alongside slot 0. Handles downstream
// backpressure and branch-resolution flushes.
module issue_pair_scheduler #(
    parameter int CTRL_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic              in_v1_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst0_i,
    input  logic [31:0]       inst1_i,
    input  logic [CTRL_W-1:0] ctrl0_i,
    input  logic [CTRL_W-1:0] ctrl1_i,
    input  logic [4:0]        rd0_i,
    input  logic              wr0_i,
    input  logic              mem0_i,
    input  logic              mem1_i,
    input  logic              br0_i,
    input  logic [4:0]        rs1_1_i,
    input  logic [4:0]        rs2_1_i,
    input  logic              use1_1_i,
    input  logic              use2_1_i,
    input  logic              out_ready_i,
    input  logic              flush_i,
    output logic              iss_v0_o,
    output logic              iss_v1_o,
    output logic [31:0]       iss_inst0_o,
    output logic [31:0]       iss_inst1_o,
    output logic [CTRL_W-1:0] iss_ctrl0_o,
    output logic [CTRL_W-1:0] iss_ctrl1_o,
    output logic              split_o
);

    typedef enum logic {PAIR = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic [31:0]       inst;
        logic [CTRL_W-1:0] ctrl;
    } slot_t;

    state_t state;
    slot_t  hold_q;

    logic adv;
    logic accept;
    logic raw;
    logic conflict;

    // Output stage advances when downstream takes the bundle or the stage is empty.
    always_comb begin
        adv        = out_ready_i | ~iss_v0_o;
        in_ready_o = (state == PAIR) & adv & ~flush_i & ~rst_i;
        accept     = in_valid_i & in_ready_o;
        // x0 never carries a dependence, so rd0 == 0 cannot create a RAW hazard.
        raw        = wr0_i & (rd0_i != 5'd0) &
                     ((use1_1_i & (rs1_1_i == rd0_i)) | (use2_1_i & (rs2_1_i == rd0_i)));
        conflict   = in_v1_i & (raw | (mem0_i & mem1_i) | br0_i);
    end

    // Pair/hold state machine with registered issue outputs; flush outranks everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= PAIR;
            hold_q      <= '0;
            iss_v0_o    <= 1'b0;
            iss_v1_o    <= 1'b0;
            iss_inst0_o <= '0;
            iss_inst1_o <= '0;
            iss_ctrl0_o <= '0;
            iss_ctrl1_o <= '0;
            split_o     <= 1'b0;
        end else if (flush_i) begin
            state    <= PAIR;
            iss_v0_o <= 1'b0;
            iss_v1_o <= 1'b0;
            split_o  <= 1'b0;
        end else begin
            split_o <= 1'b0;
            if (adv) begin
                case (state)
                    PAIR: begin
                        if (accept) begin
                            iss_v0_o    <= 1'b1;
                            iss_inst0_o <= inst0_i;
                            iss_ctrl0_o <= ctrl0_i;
                            if (conflict) begin
                                // Park slot 1; it issues alone next time the stage advances.
                                iss_v1_o <= 1'b0;
                                hold_q   <= '{inst: inst1_i, ctrl: ctrl1_i};
                                split_o  <= 1'b1;
                                state    <= HOLD;
                            end else begin
                                iss_v1_o    <= in_v1_i;
                                iss_inst1_o <= inst1_i;
                                iss_ctrl1_o <= ctrl1_i;
                            end
                        end else begin
                            iss_v0_o <= 1'b0;
                            iss_v1_o <= 1'b0;
                        end
                    end
                    HOLD: begin
                        // The held instruction is promoted to slot 0 and never paired.
                        iss_v0_o    <= 1'b1;
                        iss_v1_o    <= 1'b0;
                        iss_inst0_o <= hold_q.inst;
                        iss_ctrl0_o <= hold_q.ctrl;
                        state       <= PAIR;
                    end
                    default: state <= PAIR;
                endcase
            end
        end
    end

endmodule
